// File: rtl/handshake_ctrl_rr_sched.sv
// Round-robin scheduler that turns per-requester control tokens into a single
// registered output slot carrying a constant payload and the winning index.
module handshake_ctrl_rr_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter              CONST_VALUE = 32'h0,
  localparam int unsigned IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IW-1:0]         outs_idx,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [15:0]           tok_count
);

  // state   | meaning
  // S_EMPTY | output slot holds no token
  // S_FULL  | output slot holds a token for outs_idx, offered downstream
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OUT_CONST = DATA_WIDTH'(CONST_VALUE);
  localparam logic [IW:0]           NUM_REQ_W = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_REQ - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   tok_q, tok_d;

  logic          full;
  logic          ld;
  logic          xfer;
  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic          hshake;

  assign full = (state_q == S_FULL);
  assign ld   = !full || outs_ready;
  assign xfer = full && outs_ready;

  // Search ptr, ptr+1, ... wrapping at NUM_REQ so non-power-of-two counts never alias.
  always_comb begin
    logic [IW:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!grant_found && ctrl_valid[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  assign hshake = rst && grant_found && ld;

  // Gated by rst so no requester sees an accept while the block is held in reset.
  always_comb begin
    ctrl_ready = '0;
    if (hshake) begin
      ctrl_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    tok_d   = tok_q;
    if (xfer) begin
      tok_d = tok_q + 16'd1;
    end
    case (state_q)
      S_EMPTY: begin
        if (hshake) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (outs_ready && !hshake) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (hshake) begin
      idx_d = grant_idx;
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= '0;
      idx_q   <= '0;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      tok_q   <= tok_d;
    end
  end

  assign outs       = OUT_CONST;
  assign outs_idx   = idx_q;
  assign outs_valid = full;
  assign tok_count  = tok_q;

endmodule

// File: tb/tb_handshake_ctrl_rr_sched.sv
// Directed bench for handshake_ctrl_rr_sched: stimulus pushes expected grant
// indices into a queue, a monitor pops them as tokens leave the output slot.
module tb_handshake_ctrl_rr_sched;

  localparam logic [31:0] CONST = 32'hA5C3_0F1E;

  logic        clk;
  logic        rst;
  logic [3:0]  cv;
  logic [3:0]  cr;
  logic [31:0] outs;
  logic [1:0]  idx;
  logic        ov;
  logic        ordy;
  logic [15:0] tok;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned expq[$];

  handshake_ctrl_rr_sched #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .CONST_VALUE(CONST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_valid(cv),
    .ctrl_ready(cr),
    .outs      (outs),
    .outs_idx  (idx),
    .outs_valid(ov),
    .outs_ready(ordy),
    .tok_count (tok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: check ctrl_ready before the edge, record the expected grant.
  task automatic cyc(input logic [3:0] exp_rdy);
    @(negedge clk);
    chk("ctrl_ready", {28'h0, cr}, {28'h0, exp_rdy});
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) expq.push_back(i);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    int unsigned e;
    forever begin
      @(negedge clk);
      if (rst && ov && ordy) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_token: got idx %0d expected none at %0t", idx, $time);
        end else begin
          e = expq.pop_front();
          chk("outs_idx", {30'h0, idx}, e);
          chk("outs", outs, CONST);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    rst  = 1'b0;
    cv   = 4'b1111;
    ordy = 1'b0;
    #3;
    chk("rst_outs_valid", {31'h0, ov}, 0);
    chk("rst_ctrl_ready", {28'h0, cr}, 0);
    chk("rst_tok_count", {16'h0, tok}, 0);
    chk("rst_outs_idx", {30'h0, idx}, 0);
    chk("rst_outs", outs, CONST);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b1;

    // Full throughput rotation 0,1,2,3,0 with pointer wrap.
    cv   = 4'b1111;
    ordy = 1'b1;
    cyc(4'b0001);
    cyc(4'b0010);
    cyc(4'b0100);
    cyc(4'b1000);
    cyc(4'b0001);
    cv = 4'b0000;
    cyc(4'b0000);
    chk("rot_tok_count", {16'h0, tok}, 5);
    chk("rot_drained", {31'h0, ov}, 0);

    // Fresh pointer, sparse requesters 1 and 3.
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    #1;
    chk("rst2_tok_count", {16'h0, tok}, 0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    cv   = 4'b1010;
    ordy = 1'b1;
    cyc(4'b0010);
    cyc(4'b1000);
    cyc(4'b0010);
    cv = 4'b0000;
    cyc(4'b0000);
    chk("sparse_tok_count", {16'h0, tok}, 3);

    // Backpressure: slot holds requester 2 for three stalled cycles.
    cv   = 4'b1111;
    ordy = 1'b1;
    cyc(4'b0100);
    ordy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cyc(4'b0000);
      chk("stall_outs_valid", {31'h0, ov}, 1);
      chk("stall_outs_idx", {30'h0, idx}, 2);
      chk("stall_outs", outs, CONST);
    end
    ordy = 1'b1;
    cyc(4'b1000);
    chk("resume_outs_idx", {30'h0, idx}, 3);

    // Drain and reload in one edge, no bubble.
    cv = 4'b0100;
    cyc(4'b0100);
    chk("swap_outs_valid", {31'h0, ov}, 1);
    chk("swap_outs_idx", {30'h0, idx}, 2);
    cv = 4'b0000;
    cyc(4'b0000);
    chk("swap_tok_count", {16'h0, tok}, 6);
    chk("swap_drained", {31'h0, ov}, 0);

    // Reset while a token sits in the slot.
    cv   = 4'b1111;
    ordy = 1'b0;
    cyc(4'b1000);
    chk("pre_rst_outs_valid", {31'h0, ov}, 1);
    chk("pre_rst_outs_idx", {30'h0, idx}, 3);
    #2;
    rst = 1'b0;
    expq.delete();
    #1;
    chk("async_outs_valid", {31'h0, ov}, 0);
    chk("async_outs_idx", {30'h0, idx}, 0);
    chk("async_tok_count", {16'h0, tok}, 0);
    chk("async_ctrl_ready", {28'h0, cr}, 0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    ordy = 1'b1;
    cyc(4'b0001);
    cv = 4'b0000;
    cyc(4'b0000);
    chk("post_rst_tok_count", {16'h0, tok}, 1);

    // Counter wrap: 65534 more transfers reach 16'hFFFF, one more wraps.
    cv = 4'b1111;
    for (int k = 0; k < 65534; k++) begin
      cyc(4'b0001 << ((1 + k) % 4));
    end
    cv = 4'b0000;
    cyc(4'b0000);
    chk("tok_count_max", {16'h0, tok}, 32'hFFFF);
    cv = 4'b1111;
    cyc(4'b1000);
    cv = 4'b0000;
    cyc(4'b0000);
    chk("tok_count_wrap", {16'h0, tok}, 0);

    @(negedge clk);
    chk("queue_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/handshake_ctrl_rr_sched.md
HANDSHAKE_CTRL_RR_SCHED -- requirements
Module: handshake_ctrl_rr_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requester control channels (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the constant payload width.
REQ-003 The block SHALL have parameter CONST_VALUE, default 32'h0, giving the constant emitted with every token; it is truncated or zero-extended to DATA_WIDTH.
REQ-004 IW SHALL be a derived width equal to max(1, clog2(NUM_REQ)).
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port ctrl_valid, input, NUM_REQ bits: per-requester control-token valid.
REQ-008 Port ctrl_ready, output, NUM_REQ bits: per-requester accept; at most one bit set per cycle.
REQ-009 Port outs, output, DATA_WIDTH bits: constant payload of the output token.
REQ-010 Port outs_idx, output, IW bits: index of the requester whose token is held in the output slot.
REQ-011 Port outs_valid, output, 1 bit: output token valid.
REQ-012 Port outs_ready, input, 1 bit: downstream accept.
REQ-013 Port tok_count, output, 16 bits: running count of tokens delivered downstream.

Function
REQ-014 The block SHALL hold one registered output slot with flag full; outs_valid SHALL equal full.
REQ-015 Load enable ld SHALL be (!full) | (full & outs_ready), so one token per cycle passes at full throughput.
REQ-016 Arbitration SHALL be round-robin from pointer ptr (IW bits): grant goes to the first asserted ctrl_valid[i], searching i = ptr, ptr+1, ... modulo NUM_REQ.
REQ-017 ctrl_ready[i] SHALL be 1 only when i is granted and ld = 1; otherwise 0; it is combinational from ctrl_valid, ptr, full and outs_ready.
REQ-018 On a handshake (ctrl_valid[g] & ctrl_ready[g]), at the next edge: full <= 1, outs_idx <= g, ptr <= (g+1) mod NUM_REQ.
REQ-019 When full & outs_ready and no requester is valid, full SHALL clear at the next edge; ptr and outs_idx SHALL hold.
REQ-020 Simultaneous drain and load SHALL keep full = 1 and replace outs_idx in the same edge, with no bubble.
REQ-021 outs SHALL equal CONST_VALUE[DATA_WIDTH-1:0] at all times, including when outs_valid = 0.
REQ-022 Latency from ctrl handshake to outs_valid SHALL be exactly 1 cycle.
REQ-023 While full & !outs_ready, all ctrl_ready bits SHALL be 0 and outs_idx SHALL be stable.
REQ-024 tok_count SHALL increment by 1 on each outs_valid & outs_ready cycle and wrap from 16'hFFFF to 16'h0000.
REQ-025 The pointer SHALL wrap from NUM_REQ-1 to 0; for non-power-of-two NUM_REQ, ptr SHALL never hold a value >= NUM_REQ.

Reset
REQ-026 While rst = 0, asynchronously: full = 0 (outs_valid = 0), ptr = 0, outs_idx = 0, tok_count = 0, ctrl_ready = 0.
REQ-027 An in-flight token held in the slot when reset asserts SHALL be discarded and not counted.
REQ-028 Reset deassertion SHALL be assumed synchronized to clk externally; the first grant may occur in the first cycle with rst = 1.

Verification
REQ-029 After reset, ctrl_valid = 4'b1111 and outs_ready held at 1 -> outs_idx sequence 0,1,2,3,0 on consecutive cycles; tok_count = 5 after 5 transfers.
REQ-030 ctrl_valid = 4'b1010 with ptr = 0 -> grant 1, then 3, then 1; ctrl_ready never set for bits 0 or 2.
REQ-031 Slot full and outs_ready = 0 for 3 cycles with ctrl_valid = 4'b1111 -> ctrl_ready = 0, and outs_idx and outs stay constant until outs_ready rises.
REQ-032 Full slot, outs_ready = 1 and ctrl_valid[2] = 1 in the same cycle -> outs_valid stays 1 and outs_idx becomes 2 the next cycle.
REQ-033 Preload tok_count to 16'hFFFF (by 65535 transfers) and do one more transfer -> tok_count = 16'h0000.
REQ-034 Assert rst low mid-transfer with the slot full -> outs_valid falls immediately (asynchronously), and after release the first grant starts from index 0.
